// File: rtl/int_seq_if.sv
// -----------------------------------------------------------------------------
// sys_if
// System clock/reset bundle shared by the core blocks.
//   clk      : core clock
//   n_reset  : asynchronous active-low reset
// Modport dut is the consumer view used by int_seq.
// -----------------------------------------------------------------------------
interface sys_if;
    logic clk;
    logic n_reset;

    modport dut (
        input clk,
        input n_reset
    );
endinterface

// File: rtl/int_seq.sv
// -----------------------------------------------------------------------------
// int_seq
// Interrupt and reset sequencer for the CPU core. Arbitrates reset, NMI, BRK
// and IRQ requests (priority in that order) and runs the fixed sequence
// PUSH_H -> PUSH_L -> PUSH_P -> VEC_L -> VEC_H through the PC byte strobes,
// the stack pointer and the system bus.
//
// Ports:
//   sys        : sys_if.dut, carries clk and asynchronous active-low n_reset
//   boundary   : decoder at an instruction boundary (non-reset starts need it)
//   rdy        : bus ready, low stalls the sequence
//   n_nmi      : NMI line, falling-edge triggered
//   n_irq      : IRQ line, active-low level
//   i_flag     : interrupt-disable flag
//   brk        : decoder BRK request, sampled with boundary
//   busy       : sequence pending or running
//   done       : one-cycle pulse in VEC_H
//   sp_oe      : stack pointer drives address bus
//   sp_dec     : decrement stack pointer
//   bus_we     : system-bus write strobe (never for the reset kind)
//   pc_oeh/l   : PC high/low byte onto internal data bus
//   p_oe       : status byte onto internal data bus
//   b_flag     : B bit for the pushed status byte (BRK only)
//   vec_oe     : vec_addr drives address bus
//   vec_addr   : vector byte address
//   pc_wel/weh : load PC low/high byte
//   set_i      : set interrupt-disable flag
//
// Build option:
//   INT_SEQ_NMI_HIJACK_EN : when defined, an NMI pending as an IRQ/BRK
//   sequence enters VEC_L redirects that sequence to NMI_VEC. When undefined
//   the vector is fixed at start and the NMI runs as its own sequence later.
// -----------------------------------------------------------------------------
module int_seq #(
    parameter logic [15:0] NMI_VEC = 16'hfffa,
    parameter logic [15:0] RST_VEC = 16'hfffc,
    parameter logic [15:0] IRQ_VEC = 16'hfffe
) (
    sys_if.dut          sys,
    input  logic        boundary,
    input  logic        rdy,
    input  logic        n_nmi,
    input  logic        n_irq,
    input  logic        i_flag,
    input  logic        brk,
    output logic        busy,
    output logic        done,
    output logic        sp_oe,
    output logic        sp_dec,
    output logic        bus_we,
    output logic        pc_oeh,
    output logic        pc_oel,
    output logic        p_oe,
    output logic        b_flag,
    output logic        vec_oe,
    output logic [15:0] vec_addr,
    output logic        pc_wel,
    output logic        pc_weh,
    output logic        set_i
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PUSH_H = 3'd1,
        ST_PUSH_L = 3'd2,
        ST_PUSH_P = 3'd3,
        ST_VEC_L  = 3'd4,
        ST_VEC_H  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        K_RST = 2'd0,
        K_NMI = 2'd1,
        K_BRK = 2'd2,
        K_IRQ = 2'd3
    } kind_t;

    // Vector low-byte address selected by the latched request kind.
    function automatic logic [15:0] vec_base(input kind_t k);
        logic [15:0] base;
        case (k)
            K_RST:   base = RST_VEC;
            K_NMI:   base = NMI_VEC;
            K_BRK:   base = IRQ_VEC;
            K_IRQ:   base = IRQ_VEC;
            default: base = RST_VEC;
        endcase
        return base;
    endfunction

    // Control state
    state_t      state_r;
    state_t      state_nxt;
    kind_t       kind_r;
    kind_t       kind_nxt;
    logic        rst_pend_r;
    logic        rst_pend_nxt;
    logic        nmi_pend_r;
    logic        nmi_pend_nxt;
    logic        n_nmi_q_r;
    logic        nmi_fall_s;
    logic        irq_req_s;
    logic        enter_vec_l_s;

    // Registered outputs
    logic        busy_r;
    logic        sp_oe_r;
    logic        sp_dec_r;
    logic        bus_we_r;
    logic        pc_oeh_r;
    logic        pc_oel_r;
    logic        p_oe_r;
    logic        b_flag_r;
    logic        vec_oe_r;
    logic [15:0] vec_addr_r;
    logic        pc_wel_r;
    logic        pc_weh_r;
    logic        set_i_r;
    logic        done_r;

    // Next values of the registered outputs
    logic        busy_nxt;
    logic        sp_oe_nxt;
    logic        sp_dec_nxt;
    logic        bus_we_nxt;
    logic        pc_oeh_nxt;
    logic        pc_oel_nxt;
    logic        p_oe_nxt;
    logic        b_flag_nxt;
    logic        vec_oe_nxt;
    logic [15:0] vec_addr_nxt;
    logic        pc_wel_nxt;
    logic        pc_weh_nxt;
    logic        set_i_nxt;
    logic        done_nxt;

    // The previous n_nmi sample resets high so a line held low through reset
    // does not produce a spurious edge on release.
    assign nmi_fall_s = n_nmi_q_r & ~n_nmi;
    assign irq_req_s  = ~n_irq & ~i_flag;

    // Next state, request kind and pending-source bookkeeping.
    always_comb begin
        state_nxt     = state_r;
        kind_nxt      = kind_r;
        rst_pend_nxt  = rst_pend_r;
        nmi_pend_nxt  = nmi_pend_r | nmi_fall_s;
        enter_vec_l_s = 1'b0;
        if (rdy) begin
            case (state_r)
                ST_IDLE: begin
                    if (rst_pend_r) begin
                        state_nxt = ST_PUSH_H;
                        kind_nxt  = K_RST;
                    end else if (boundary && nmi_pend_r) begin
                        state_nxt = ST_PUSH_H;
                        kind_nxt  = K_NMI;
                    end else if (boundary && brk) begin
                        state_nxt = ST_PUSH_H;
                        kind_nxt  = K_BRK;
                    end else if (boundary && irq_req_s) begin
                        state_nxt = ST_PUSH_H;
                        kind_nxt  = K_IRQ;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_PUSH_H: state_nxt = ST_PUSH_L;
                ST_PUSH_L: state_nxt = ST_PUSH_P;
                ST_PUSH_P: begin
                    state_nxt     = ST_VEC_L;
                    enter_vec_l_s = 1'b1;
`ifdef INT_SEQ_NMI_HIJACK_EN
                    // The status byte (with its B bit) is already pushed; only
                    // the vector fetch is redirected.
                    if (nmi_pend_r && ((kind_r == K_BRK) || (kind_r == K_IRQ))) begin
                        kind_nxt = K_NMI;
                    end else begin
                        kind_nxt = kind_r;
                    end
`endif
                end
                ST_VEC_L:  state_nxt = ST_VEC_H;
                ST_VEC_H:  state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end else begin
            state_nxt = state_r;
        end

        // Pending sources are retired as their vector fetch begins; an NMI
        // edge arriving in the same cycle is absorbed by the one being served.
        if (enter_vec_l_s && (kind_nxt == K_RST)) begin
            rst_pend_nxt = 1'b0;
        end else begin
            rst_pend_nxt = rst_pend_r;
        end
        if (enter_vec_l_s && (kind_nxt == K_NMI)) begin
            nmi_pend_nxt = 1'b0;
        end else begin
            nmi_pend_nxt = nmi_pend_r | nmi_fall_s;
        end
    end

    // Output decode from the next state so every output comes from a flop.
    always_comb begin
        busy_nxt     = (state_nxt != ST_IDLE) | rst_pend_nxt;
        sp_oe_nxt    = 1'b0;
        sp_dec_nxt   = 1'b0;
        bus_we_nxt   = 1'b0;
        pc_oeh_nxt   = 1'b0;
        pc_oel_nxt   = 1'b0;
        p_oe_nxt     = 1'b0;
        b_flag_nxt   = 1'b0;
        vec_oe_nxt   = 1'b0;
        vec_addr_nxt = vec_base(kind_nxt);
        pc_wel_nxt   = 1'b0;
        pc_weh_nxt   = 1'b0;
        set_i_nxt    = 1'b0;
        done_nxt     = 1'b0;
        case (state_nxt)
            ST_PUSH_H: begin
                sp_oe_nxt  = 1'b1;
                sp_dec_nxt = 1'b1;
                pc_oeh_nxt = 1'b1;
                bus_we_nxt = (kind_nxt != K_RST);
            end
            ST_PUSH_L: begin
                sp_oe_nxt  = 1'b1;
                sp_dec_nxt = 1'b1;
                pc_oel_nxt = 1'b1;
                bus_we_nxt = (kind_nxt != K_RST);
            end
            ST_PUSH_P: begin
                sp_oe_nxt  = 1'b1;
                sp_dec_nxt = 1'b1;
                p_oe_nxt   = 1'b1;
                bus_we_nxt = (kind_nxt != K_RST);
                b_flag_nxt = (kind_nxt == K_BRK);
            end
            ST_VEC_L: begin
                vec_oe_nxt = 1'b1;
                pc_wel_nxt = 1'b1;
                set_i_nxt  = 1'b1;
            end
            ST_VEC_H: begin
                vec_oe_nxt   = 1'b1;
                vec_addr_nxt = vec_base(kind_nxt) + 16'd1;
                pc_weh_nxt   = 1'b1;
                done_nxt     = 1'b1;
            end
            default: begin
                sp_oe_nxt = 1'b0;
            end
        endcase
    end

    // Sequencer state, request kind, pending flags and NMI edge sampler.
    always_ff @(posedge sys.clk or negedge sys.n_reset) begin
        if (!sys.n_reset) begin
            state_r    <= ST_IDLE;
            kind_r     <= K_RST;
            rst_pend_r <= 1'b1;
            nmi_pend_r <= 1'b0;
            n_nmi_q_r  <= 1'b1;
        end else begin
            state_r    <= state_nxt;
            kind_r     <= kind_nxt;
            rst_pend_r <= rst_pend_nxt;
            nmi_pend_r <= nmi_pend_nxt;
            n_nmi_q_r  <= n_nmi;
        end
    end

    // Output registers.
    always_ff @(posedge sys.clk or negedge sys.n_reset) begin
        if (!sys.n_reset) begin
            busy_r     <= 1'b1;
            sp_oe_r    <= 1'b0;
            sp_dec_r   <= 1'b0;
            bus_we_r   <= 1'b0;
            pc_oeh_r   <= 1'b0;
            pc_oel_r   <= 1'b0;
            p_oe_r     <= 1'b0;
            b_flag_r   <= 1'b0;
            vec_oe_r   <= 1'b0;
            vec_addr_r <= RST_VEC;
            pc_wel_r   <= 1'b0;
            pc_weh_r   <= 1'b0;
            set_i_r    <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            busy_r     <= busy_nxt;
            sp_oe_r    <= sp_oe_nxt;
            sp_dec_r   <= sp_dec_nxt;
            bus_we_r   <= bus_we_nxt;
            pc_oeh_r   <= pc_oeh_nxt;
            pc_oel_r   <= pc_oel_nxt;
            p_oe_r     <= p_oe_nxt;
            b_flag_r   <= b_flag_nxt;
            vec_oe_r   <= vec_oe_nxt;
            vec_addr_r <= vec_addr_nxt;
            pc_wel_r   <= pc_wel_nxt;
            pc_weh_r   <= pc_weh_nxt;
            set_i_r    <= set_i_nxt;
            done_r     <= done_nxt;
        end
    end

    // Select outputs hold through a stall; strobes must drop in the very
    // cycle rdy is low, so they are qualified with the live rdy.
    assign busy     = busy_r;
    assign sp_oe    = sp_oe_r;
    assign pc_oeh   = pc_oeh_r;
    assign pc_oel   = pc_oel_r;
    assign p_oe     = p_oe_r;
    assign b_flag   = b_flag_r;
    assign vec_oe   = vec_oe_r;
    assign vec_addr = vec_addr_r;
    assign sp_dec   = sp_dec_r & rdy;
    assign bus_we   = bus_we_r & rdy;
    assign pc_wel   = pc_wel_r & rdy;
    assign pc_weh   = pc_weh_r & rdy;
    assign set_i    = set_i_r  & rdy;
    assign done     = done_r   & rdy;

endmodule

// File: doc/int_seq.md
# int_seq

Interrupt and reset sequencer for the CPU core. It arbitrates reset, NMI, IRQ and BRK requests and runs the fixed 5-state stack-push and vector-fetch sequence. The sequence is driven through the program counter's byte read/write strobes, the stack pointer and the system bus. It sits beside the instruction decoder, which hands over control at instruction boundaries and suppresses its own PC increments while `busy` is high.

## Interface
Parameters:
- `NMI_VEC`, 16'hfffa, NMI vector low-byte address
- `RST_VEC`, 16'hfffc, reset vector low-byte address
- `IRQ_VEC`, 16'hfffe, IRQ/BRK vector low-byte address

Ports:
- `sys.clk`  input  1  clock, carried in the `sys` (sys_if) interface port
- `sys.n_reset`  input  1  asynchronous active-low reset, carried in `sys`
- `boundary`  input  1  decoder is at an instruction boundary; a request may start
- `rdy`  input  1  bus ready; low stalls the sequence
- `n_nmi`  input  1  NMI line, falling-edge triggered
- `n_irq`  input  1  IRQ line, level, active-low
- `i_flag`  input  1  interrupt-disable flag from the status register
- `brk`  input  1  decoder requests a BRK sequence; sampled with `boundary`
- `busy`  output  1  sequence is pending or running
- `done`  output  1  one-cycle pulse on the last sequence cycle
- `sp_oe`  output  1  stack pointer (page 1) drives the address bus
- `sp_dec`  output  1  decrement stack pointer
- `bus_we`  output  1  system-bus write strobe
- `pc_oeh`, `pc_oel`  output  1 each  PC high/low byte onto the internal data bus
- `p_oe`  output  1  status byte onto the internal data bus
- `b_flag`  output  1  B bit value for the pushed status byte
- `vec_oe`  output  1  `vec_addr` drives the address bus
- `vec_addr`  output  16  vector byte address
- `pc_wel`, `pc_weh`  output  1 each  load PC low/high byte from the data bus
- `set_i`  output  1  set the interrupt-disable flag

## Operation
- States: IDLE, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H.
- Pending sources:
  - `rst_pend` is set by reset and cleared on entering VEC_L.
  - `nmi_pend` is set on a registered falling edge of `n_nmi` and cleared on entering VEC_L with the NMI vector.
  - The IRQ request is the live level `~n_irq & ~i_flag`.
- Start: in IDLE, the highest pending request wins and moves to PUSH_H.
  - Priority is reset > NMI > BRK > IRQ.
  - Reset starts without `boundary`. All other requests need `boundary`=1.
- The kind is latched at start and selects the vector: RST_VEC, NMI_VEC, or IRQ_VEC (BRK and IRQ both use IRQ_VEC).
- State outputs:
  - PUSH_H: `sp_oe`, `pc_oeh`, `bus_we`, `sp_dec`.
  - PUSH_L: `sp_oe`, `pc_oel`, `bus_we`, `sp_dec`.
  - PUSH_P: `sp_oe`, `p_oe`, `bus_we`, `sp_dec`. `b_flag`=1 only for BRK.
  - VEC_L: `vec_oe`, `vec_addr`=base, `pc_wel`, `set_i`.
  - VEC_H: `vec_oe`, `vec_addr`=base+1, `pc_weh`, `done`. Then return to IDLE.
- Reset kind: `bus_we` is never asserted (dummy stack reads). `sp_dec` still pulses in each push state.
- `vec_addr` is base+1 with no carry out of 16 bits; all defaults are even, so there is no wrap.
- `busy` = (state != IDLE) | `rst_pend`.

## Timing
- Reset values:
  - State IDLE, `rst_pend`=1, `nmi_pend`=0.
  - `busy`=1 and `vec_addr`=RST_VEC.
  - All other outputs 0.
- Request accepted in cycle N; PUSH_H occupies N+1 and VEC_H occupies N+5. The sequence is 5 cycles with `rdy` held high.
- `rdy`=0 holds the current state. While stalled, `bus_we`, `sp_dec`, `pc_wel`, `pc_weh`, `set_i` and `done` are forced to 0. Address/data select outputs keep their values.
- The NMI edge detector samples `n_nmi` every cycle, including while busy and stalled. A second edge while `nmi_pend`=1 is absorbed.
- An IRQ that is deasserted before acceptance is lost (level semantics). It is never latched.
- Reset asserted mid-sequence returns asynchronously to the reset values. The reset sequence then starts on the first clock after release.
- Accepting a request in the same cycle VEC_H completes is not allowed. IDLE lasts at least one cycle between sequences.

## Configuration
- `INT_SEQ_NMI_HIJACK_EN`:
  - Defined: if `nmi_pend` is 1 when an IRQ or BRK sequence enters VEC_L, the vector becomes NMI_VEC and `nmi_pend` clears. `b_flag` is already pushed and stays unchanged.
  - Undefined: the vector is fixed at start, and the NMI is taken at the next boundary after completion.

## Test plan
- Release reset with `rdy`=1 → `busy`=1 for 5 cycles and no `bus_we`. `vec_addr` is fffc then fffd, with `pc_wel`/`pc_weh` in cycles 4/5. `done` pulses in cycle 5.
- `n_irq`=0, `i_flag`=0, `boundary`=1 → `bus_we` high in 3 push cycles, `b_flag`=0, vector fffe/ffff, `set_i` in VEC_L. With `i_flag`=1 there is no start.
- `brk`=1 and `n_irq`=0 at the same boundary → BRK wins, `b_flag`=1 in PUSH_P, vector fffe.
- NMI falling edge during PUSH_L of an IRQ sequence:
  - With the macro: vector fffa/fffb and no second sequence.
  - Without the macro: vector fffe, then the NMI sequence follows after 1 IDLE cycle.
- `rdy`=0 for 3 cycles in PUSH_P → state held and no strobes. The sequence completes 3 cycles late with exactly 3 `sp_dec` pulses total.
- Assert reset in VEC_L of an NMI sequence → outputs return to reset values immediately, and after release a full reset sequence runs to fffc.
